// File: rtl/cache_prof_pkg.sv
// Shared types and address-split helpers for the cache trace profiler.
package cache_prof_pkg;

   localparam int unsigned ADDR_W_DEF = 32;

   typedef enum logic {READY, STALL} state_e;

   function automatic int unsigned offset_w(input int unsigned block_bytes);
      return $clog2(block_bytes);
   endfunction

   function automatic int unsigned index_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned block_bytes,
                                         input int unsigned sets);
      return addr_w - offset_w(block_bytes) - index_w(sets);
   endfunction

endpackage

// File: rtl/cache_prof_tag_array.sv
// Direct-mapped tag store: combinational read, synchronous write, synchronous clear of valid bits.
module cache_prof_tag_array #(
   parameter int unsigned SETS  = 16,
   parameter int unsigned TAG_W = 23
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [$clog2(SETS)-1:0] rd_index,
   output logic [TAG_W-1:0]        rd_tag,
   output logic                    rd_valid,
   input  logic                    wr_en,
   input  logic [$clog2(SETS)-1:0] wr_index,
   input  logic [TAG_W-1:0]        wr_tag
);

   logic [TAG_W-1:0] tags [SETS];
   logic [SETS-1:0]  valid_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tags need no reset; a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index] <= wr_tag;
      end
   end

   assign rd_tag   = tags[rd_index];
   assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/cache_trace_profiler.sv
// Direct-mapped cache behaviour monitor with hit/miss counters.
// Optional miss-stall model enabled by defining CACHE_PROF_MISS_STALL_EN.
module cache_trace_profiler
   import cache_prof_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned BLOCK_BYTES  = 32,
   parameter int unsigned SETS         = 16,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned MISS_PENALTY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   output logic              hit_o,
   output logic              miss_o,
   output logic [CNT_W-1:0]  access_cnt_o,
   output logic [CNT_W-1:0]  hit_cnt_o,
   output logic [CNT_W-1:0]  miss_cnt_o
);

   localparam int unsigned OFFSET_W = offset_w(BLOCK_BYTES);
   localparam int unsigned INDEX_W  = index_w(SETS);
   localparam int unsigned TAG_W    = tag_w(ADDR_W, BLOCK_BYTES, SETS);

   logic               flush;
   logic               accept;
   logic               lookup_hit;
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic [TAG_W-1:0]   rd_tag;
   logic               rd_valid;
   logic               unused_offset;

   logic               hit_q, miss_q;
   logic [CNT_W-1:0]   access_cnt_q, hit_cnt_q, miss_cnt_q;

   assign flush         = rst_i || clr_i;
   assign index         = req_addr_i[OFFSET_W +: INDEX_W];
   assign tag           = req_addr_i[ADDR_W-1 -: TAG_W];
   assign unused_offset = ^req_addr_i[OFFSET_W-1:0];
   assign accept        = req_valid_i && req_ready_o;
   assign lookup_hit    = rd_valid && (rd_tag == tag);

   cache_prof_tag_array #(
      .SETS  (SETS),
      .TAG_W (TAG_W)
   ) u_tag_array (
      .clk      (clk_i),
      .clr      (flush),
      .rd_index (index),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .wr_en    (accept && !lookup_hit),
      .wr_index (index),
      .wr_tag   (tag)
   );

`ifdef CACHE_PROF_MISS_STALL_EN
   localparam int unsigned STALL_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

   state_e             state_q;
   logic [STALL_W-1:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (flush) begin
         state_q     <= READY;
         stall_cnt_q <= '0;
      end else begin
         case (state_q)
            READY: begin
               if (accept && !lookup_hit) begin
                  state_q     <= STALL;
                  stall_cnt_q <= STALL_W'(MISS_PENALTY - 1);
               end
            end
            STALL: begin
               if (stall_cnt_q == '0) begin
                  state_q <= READY;
               end else begin
                  stall_cnt_q <= stall_cnt_q - 1'b1;
               end
            end
            default: state_q <= READY;
         endcase
      end
   end

   assign req_ready_o = !flush && (state_q == READY);
`else
   logic unused_penalty;
   assign unused_penalty = ^MISS_PENALTY;
   assign req_ready_o    = !flush;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (flush) begin
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         access_cnt_q <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         hit_q  <= accept && lookup_hit;
         miss_q <= accept && !lookup_hit;
         if (accept) begin
            access_cnt_q <= sat_inc(access_cnt_q);
            if (lookup_hit) begin
               hit_cnt_q <= sat_inc(hit_cnt_q);
            end else begin
               miss_cnt_q <= sat_inc(miss_cnt_q);
            end
         end
      end
   end

   assign hit_o        = hit_q;
   assign miss_o       = miss_q;
   assign access_cnt_o = access_cnt_q;
   assign hit_cnt_o    = hit_cnt_q;
   assign miss_cnt_o   = miss_cnt_q;

endmodule
